// File: rtl/stepper_step_gen_pkg.sv
// Shared types and board defaults for the stepper step-pulse generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stepper_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ramp endpoints for the 12 MHz board clock: 10 ms start/stop period
    localparam int DEF_START_PER = 120000;
    localparam int DEF_RAMP_DEC  = 4000;

endpackage

// File: rtl/stepper_step_gen_step_ramp_calc.sv
// Next step period / ramp depth for a linear accel-cruise-decel profile.
// Latency: purely combinational.
// Backpressure: none; evaluated only on step cycles by the parent.
module step_ramp_calc
    import stepper_step_gen_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 24,
    parameter int START_PER = DEF_START_PER,
    parameter int RAMP_DEC  = DEF_RAMP_DEC
) (
    input  logic [PER_W-1:0] cur_per,
    input  logic [PER_W-1:0] tgt,
    input  logic [CNT_W-1:0] rem_after,
    input  logic [CNT_W-1:0] ramp_cnt,
    output logic [PER_W-1:0] nxt_per,
    output logic [CNT_W-1:0] nxt_ramp
);

    // One extra bit so sums and differences never wrap before comparing
    logic [PER_W:0] cur_ext;
    logic [PER_W:0] tgt_ext;
    logic [PER_W:0] start_ext;
    logic [PER_W:0] dec_ext;
    logic [PER_W:0] inc_sum;

    assign cur_ext   = {1'b0, cur_per};
    assign tgt_ext   = {1'b0, tgt};
    assign start_ext = (PER_W+1)'(START_PER);
    assign dec_ext   = (PER_W+1)'(RAMP_DEC);
    assign inc_sum   = cur_ext + dec_ext;

    // Decelerate once the remaining steps fit inside the ramp already climbed,
    // otherwise accelerate toward the target, otherwise cruise.
    always_comb begin
        nxt_per  = cur_per;
        nxt_ramp = ramp_cnt;
        if ((rem_after <= ramp_cnt) && (cur_ext < start_ext)) begin
            nxt_per  = (inc_sum > start_ext) ? start_ext[PER_W-1:0] : inc_sum[PER_W-1:0];
            nxt_ramp = ramp_cnt - CNT_W'(1);
        end else if (cur_per > tgt) begin
            nxt_per  = (cur_ext > (tgt_ext + dec_ext)) ? (cur_per - dec_ext[PER_W-1:0]) : tgt;
            nxt_ramp = ramp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stepper_step_gen.sv
// Step-pulse generator: accepts a move, emits ramped one-cycle step strobes, tracks position.
// Latency: first step cur_per cycles after acceptance; done one cycle after last step/abort.
// Backpressure: cmd_ready high only in IDLE; commands offered while busy are dropped.
module stepper_step_gen
    import stepper_step_gen_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 24,
    parameter int POS_W     = 24,
    parameter int START_PER = DEF_START_PER,
    parameter int RAMP_DEC  = DEF_RAMP_DEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    localparam logic [PER_W-1:0] START_P = PER_W'(START_PER);
    localparam logic [PER_W-1:0] MIN_PER = PER_W'(2);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ramp_q, ramp_d;
    logic [PER_W-1:0] tgt_q, tgt_d;
    logic [PER_W-1:0] cur_per_q, cur_per_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PER_W-1:0] tgt_in;
    logic [CNT_W-1:0] rem_dec;
    logic [PER_W-1:0] ramp_per;
    logic [CNT_W-1:0] ramp_nxt;

    // A period of 1 could never produce a distinct strobe, so clamp to 2
    assign tgt_in    = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;
    assign rem_dec   = rem_q - CNT_W'(1);
    assign cmd_ready = (state_q == ST_IDLE);

    assign step = step_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pos  = pos_q;

    step_ramp_calc #(
        .CNT_W     (CNT_W),
        .PER_W     (PER_W),
        .START_PER (START_PER),
        .RAMP_DEC  (RAMP_DEC)
    ) u_ramp (
        .cur_per   (cur_per_q),
        .tgt       (tgt_q),
        .rem_after (rem_dec),
        .ramp_cnt  (ramp_q),
        .nxt_per   (ramp_per),
        .nxt_ramp  (ramp_nxt)
    );

    // State and datapath registers, synchronous reset drops any move in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            rem_q     <= '0;
            ramp_q    <= '0;
            tgt_q     <= '0;
            cur_per_q <= '0;
            timer_q   <= '0;
            pos_q     <= '0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rem_q     <= rem_d;
            ramp_q    <= ramp_d;
            tgt_q     <= tgt_d;
            cur_per_q <= cur_per_d;
            timer_q   <= timer_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state: a zero-step move spends one cycle in RUN before finishing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (abort || (rem_q == '0) || (step_q && (rem_q == CNT_W'(1)))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; step_q marks the cycle timer hits cur_per-1
    always_comb begin
        dir_d     = dir_q;
        rem_d     = rem_q;
        ramp_d    = ramp_q;
        tgt_d     = tgt_q;
        cur_per_d = cur_per_q;
        timer_d   = timer_q;
        pos_d     = pos_q;
        if ((state_q == ST_IDLE) && cmd_valid) begin
            dir_d     = cmd_dir;
            rem_d     = cmd_steps;
            tgt_d     = tgt_in;
            cur_per_d = (START_P > tgt_in) ? START_P : tgt_in;
            timer_d   = '0;
            ramp_d    = '0;
        end else if (state_q == ST_RUN) begin
            if (step_q) begin
                timer_d   = '0;
                rem_d     = rem_dec;
                pos_d     = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                cur_per_d = ramp_per;
                ramp_d    = ramp_nxt;
            end else begin
                timer_d = timer_q + PER_W'(1);
            end
        end
        step_d = (state_d == ST_RUN) && (timer_d == (cur_per_d - PER_W'(1)));
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
// Bench for stepper_step_gen with a small ramp (START_PER=10, RAMP_DEC=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_stepper_step_gen;

    localparam int S = 10;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_dir, abort;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        cmd_ready, step, dir, busy, done;
    logic [23:0] pos;
    logic        r4, s4, d4, b4, dn4;
    logic [3:0]  pos4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_pos = 0;
    int last_n = 0;
    int dir_glitch = 0;
    int exp_done = 0;
    int exp_t[$];
    int step_t[$];
    int done_t[$];

    stepper_step_gen #(.CNT_W(16), .PER_W(24), .POS_W(24), .START_PER(S), .RAMP_DEC(D)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .step(step), .dir(dir),
        .busy(busy), .done(done), .pos(pos));

    stepper_step_gen #(.CNT_W(16), .PER_W(24), .POS_W(4), .START_PER(S), .RAMP_DEC(D)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(r4), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .step(s4), .dir(d4),
        .busy(b4), .done(dn4), .pos(pos4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step) step_t.push_back(cyc);
        if (done) done_t.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected step offsets from acceptance, straight from the ramp rules
    task automatic build_model(input int steps, input int period, input int ab);
        int tgt, per, ramp, rem, t;
        exp_t.delete();
        tgt = (period < 2) ? 2 : period;
        per = (S > tgt) ? S : tgt;
        ramp = 0; rem = steps; t = 0;
        for (int i = 0; i < steps; i++) begin
            t += per;
            if (ab != 0 && t > ab) break;
            exp_t.push_back(t);
            rem--;
            if (rem <= ramp && per < S) begin
                per = (per + D > S) ? S : per + D;
                ramp--;
            end else if (per > tgt) begin
                per = (per - D < tgt) ? tgt : per - D;
                ramp++;
            end
        end
        if (steps == 0) exp_done = 2;
        else if (exp_t.size() < steps) exp_done = ab + 1;
        else exp_done = exp_t[exp_t.size()-1] + 1;
    endtask

    task automatic wait_done(input int n, input int ab, input bit d);
        dir_glitch = 0;
        for (int k = 0; k < 3000 && done_t.size() == 0; k++) begin
            abort = (ab != 0 && cyc == n + ab);
            if (busy && dir !== d) dir_glitch++;
            tick();
        end
        abort = 0;
    endtask

    task automatic do_move(input bit d, input int steps, input int period, input int ab, input string nm);
        int n, errs;
        logic [23:0] ep;
        logic [3:0] ep4;
        build_model(steps, period, ab);
        tick();
        step_t.delete(); done_t.delete();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", nm, cmd_ready); end
        cmd_valid = 1; cmd_dir = d; cmd_steps = 16'(steps); cmd_period = 24'(period);
        n = cyc; last_n = n;
        tick();
        cmd_valid = 0;
        total++;
        if (busy !== 1'b1 || dir !== d) begin
            bad++; $display("FAIL %s busy_dir: got busy=%b dir=%b want busy=1 dir=%b", nm, busy, dir, d);
        end
        wait_done(n, ab, d);
        total++;
        if (done_t.size() == 0) begin bad++; $display("FAIL %s timeout: got no done want done", nm); return; end
        total++;
        if (dir_glitch != 0) begin bad++; $display("FAIL %s dir_stable: got %0d changes want 0", nm, dir_glitch); end
        total++;
        if (step_t.size() != exp_t.size()) begin
            bad++; $display("FAIL %s step_count: got %0d want %0d", nm, step_t.size(), exp_t.size());
        end
        errs = 0;
        for (int i = 0; i < step_t.size() && i < exp_t.size(); i++)
            if (step_t[i] - n != exp_t[i]) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL %s step_times: got %0d wrong want 0 wrong", nm, errs); end
        total++;
        if (done_t[0] - n != exp_done) begin
            bad++; $display("FAIL %s done_time: got N+%0d want N+%0d", nm, done_t[0] - n, exp_done);
        end
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL %s at_done: got ready=%b busy=%b want ready=0 busy=1", nm, cmd_ready, busy);
        end
        exp_pos += d ? exp_t.size() : -exp_t.size();
        tick();
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL %s after_done: got ready=%b busy=%b done=%b want 1 0 0", nm, cmd_ready, busy, done);
        end
        ep = exp_pos[23:0]; ep4 = exp_pos[3:0];
        total++;
        if (pos !== ep) begin bad++; $display("FAIL %s pos: got %0h want %0h", nm, pos, ep); end
        total++;
        if (pos4 !== ep4) begin bad++; $display("FAIL %s pos4: got %0h want %0h", nm, pos4, ep4); end
        tick();
        total++;
        if (done_t.size() != 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", nm, done_t.size()); end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if (step !== 0 || busy !== 0 || done !== 0 || dir !== 0 || pos !== 0) begin
            bad++; $display("FAIL reset_outs: got step=%b busy=%b done=%b dir=%b pos=%0h want all 0", step, busy, done, dir, pos);
        end
        rst = 0;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || pos4 !== 4'h0) begin
            bad++; $display("FAIL reset_ready: got ready=%b pos4=%0h want 1 0", cmd_ready, pos4);
        end
    endtask

    task automatic test_ramp();
        int iv[8];
        int prev, errs;
        iv = '{10, 8, 6, 4, 4, 6, 8, 10};
        do_move(0, 8, 4, 0, "accel_decel");
        errs = 0; prev = last_n;
        for (int i = 0; i < 8 && i < step_t.size(); i++) begin
            if (step_t[i] - prev != iv[i]) errs++;
            prev = step_t[i];
        end
        total++;
        if (errs != 0 || step_t.size() != 8) begin
            bad++; $display("FAIL ramp_intervals: got %0d wrong of %0d want 0 of 8", errs, step_t.size());
        end
        total++;
        if (pos !== 24'hfffff8) begin bad++; $display("FAIL ramp_pos: got %0h want fffff8", pos); end
        do_move(1, 3, 10, 0, "cruise3");
    endtask

    task automatic test_zero();
        do_move(1, 0, 5, 0, "zero_steps");
    endtask

    task automatic test_abort();
        // 5-step move, period 4: steps at N+10 and N+18, abort lands on the second
        do_move(1, 5, 4, 18, "abort_on_step");
        total++;
        if (step_t.size() != 2) begin bad++; $display("FAIL abort_count: got %0d want 2", step_t.size()); end
    endtask

    task automatic test_busy_ignore();
        int n, n2, errs;
        tick();
        step_t.delete(); done_t.delete();
        cmd_valid = 1; cmd_dir = 1; cmd_steps = 3; cmd_period = 10; n = cyc;
        tick();
        cmd_dir = 0; cmd_steps = 2; cmd_period = 6;
        wait_done(n, 0, 1);
        total++;
        if (done_t.size() == 0 || dir_glitch != 0 || step_t.size() != 3) begin
            bad++; $display("FAIL busy_first: got done=%0d glitch=%0d steps=%0d want 1 0 3", done_t.size(), dir_glitch, step_t.size());
        end
        exp_pos += 3;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL busy_reaccept: got ready=%b want 1", cmd_ready); end
        n2 = cyc;
        step_t.delete(); done_t.delete();
        tick();
        cmd_valid = 0;
        total++;
        if (dir !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_second_dir: got dir=%b busy=%b want 0 1", dir, busy);
        end
        build_model(2, 6, 0);
        wait_done(n2, 0, 0);
        errs = 0;
        for (int i = 0; i < step_t.size() && i < exp_t.size(); i++)
            if (step_t[i] - n2 != exp_t[i]) errs++;
        total++;
        if (done_t.size() == 0 || step_t.size() != 2 || errs != 0 || done_t[0] - n2 != exp_done) begin
            bad++; $display("FAIL busy_second_move: got steps=%0d wrong=%0d done=%0d want 2 0 1", step_t.size(), errs, done_t.size());
        end
        exp_pos -= 2;
        tick();
        total++;
        if (pos !== 24'(exp_pos)) begin bad++; $display("FAIL busy_pos: got %0h want %0h", pos, 24'(exp_pos)); end
    endtask

    task automatic test_reset_mid();
        tick();
        step_t.delete(); done_t.delete();
        cmd_valid = 1; cmd_dir = 1; cmd_steps = 5; cmd_period = 4;
        tick();
        cmd_valid = 0;
        for (int k = 0; k < 200 && step_t.size() < 2; k++) tick();
        total++;
        if (step_t.size() < 2) begin bad++; $display("FAIL rstmid_steps: got %0d want 2", step_t.size()); end
        rst = 1;
        tick();
        total++;
        if (step !== 0 || busy !== 0 || pos !== 0 || cmd_ready !== 1 || done !== 0) begin
            bad++; $display("FAIL rstmid_outs: got step=%b busy=%b pos=%0h ready=%b done=%b want 0 0 0 1 0", step, busy, pos, cmd_ready, done);
        end
        rst = 0; exp_pos = 0;
        step_t.delete(); done_t.delete();
        repeat (30) tick();
        total++;
        if (done_t.size() != 0 || step_t.size() != 0) begin
            bad++; $display("FAIL rstmid_quiet: got done=%0d steps=%0d want 0 0", done_t.size(), step_t.size());
        end
    endtask

    task automatic test_wrap();
        do_move(1, 7, 2, 0, "wrap_a");
        do_move(1, 9, 2, 0, "wrap_b");
        total++;
        if (pos4 !== 4'h0 || pos !== 24'd16) begin
            bad++; $display("FAIL wrap: got pos4=%0h pos=%0d want 0 16", pos4, pos);
        end
    endtask

    task automatic test_random();
        int steps, per, ab;
        bit d;
        for (int i = 0; i < 8; i++) begin
            d = 1'($urandom_range(0, 1));
            steps = $urandom_range(0, 12);
            per = $urandom_range(0, 14);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
            do_move(d, steps, per, ab, "random");
        end
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_dir = 0; cmd_steps = 0; cmd_period = 0; abort = 0;
        test_reset();
        test_ramp();
        test_zero();
        test_abort();
        test_busy_ignore();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
